base_rr_stage: RTL and testbench
================================

# base_rr_stage

Round-robin arbitrated pipeline stage. It shares one registered output slot among `ways` requesters, each using a valid/ready handshake, and presents the winner's data, plus the winner's index, on a single valid/ready output. It sits in front of shared AFU datapath resources (command issue, register-write paths) where several engines compete for one registered port.

## Interface
- `ways`, 4, number of requesters; 2..16.
- `width`, 8, data width per requester.
- `idw`, 2, index width; equals clog2(`ways`); must be ≥1.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `i_v` input `ways`: per-requester valid.
- `i_d` input `ways`*`width`: requester k's data is bits [k*`width` +: `width`].
- `i_r` output `ways`: per-requester ready; combinational.
- `o_v` output 1: output slot valid; registered.
- `o_r` input 1: downstream ready.
- `o_d` output `width`: registered winner data.
- `o_id` output `idw`: registered winner index.

## Operation
- Define load = ~o_v | o_r. The slot accepts new data when it is empty or is draining in the same cycle.
- Priority pointer `ptr` (`idw` bits) marks the highest-priority requester.
- Winner selection:
  - The winner is the first k with i_v[k]=1, searching `ptr`, `ptr`+1, … and wrapping modulo `ways`.
  - i_r[winner] = load. All other i_r bits are 0.
  - When no requester is valid, i_r = 0.
- Accept (load & |i_v), on the clock edge:
  - o_d ← winner data; o_id ← winner; o_v ← 1.
  - `ptr` ← winner+1, wrapping from `ways`-1 to 0. When `ways` is not a power of 2, wrap explicitly; never rely on overflow.
- Drain only (load & ~|i_v): o_v ← 0. o_d and o_id hold their values (don't-care).
- Stall (o_v & ~o_r): all state holds; i_r = 0.
- Requester rules:
  - Once i_v[k] is asserted, it stays asserted with stable data until i_r[k]=1 in the same cycle.
  - A requester that drops valid without a handshake is a protocol violation; the bench asserts on it.
- Simultaneous drain and accept in one cycle is a single transfer in, a single transfer out, with no bubble.
- `ptr` moves only on accept. Idle cycles and stalls do not rotate it.
- Fairness: with all requesters continuously valid and o_r=1, grants cycle 0,1,…,`ways`-1,0,…. A waiting requester is granted within `ways` accepts.

## Timing
- Reset values: o_v=0, o_d=0, o_id=0, ptr=0. i_r=0 during reset, because it is gated by load, and reset forces o_v=0 and load=1… so i_r is additionally forced to 0 while reset is high.
- Reset mid-transfer: the held entry is discarded; no handshake completes during reset.
- Latency: an entry accepted at edge N is visible on o_v/o_d at N (registered outputs), and is consumed at the first edge with o_r=1.
- Throughput: 1 transfer per cycle when o_r is held high.
- Combinational paths: o_r→i_r and i_v→i_r. There is no path from i_d to any output.
- No state machine beyond o_v (EMPTY/FULL) and `ptr`:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain only.
  - FULL→FULL on stall or on drain-with-accept.

## Structure
- Shared package `base_pkg`: clog2 function used to derive `idw`, and a lint check that `idw` matches `ways`.
- Sub-module `base_rr_pick`: purely combinational.
  - Inputs: `ways`-bit request vector and `ptr`.
  - Outputs: a one-hot grant, the encoded index, and an `any` flag.
  - Implement with a double-width masked priority encode (requests at or above `ptr` first, then all requests).
- Top level holds the o_v/o_d/o_id register (asynchronous reset, values as above), the `ptr` register, and the load/i_r logic.

## Test plan
- Reset then idle: after reset, o_v=0, o_id=0, i_r=0000. Hold i_v=0 for 10 cycles → ptr stays 0 and o_v stays 0.
- Single requester: i_v=0100 with data 0xA5 and o_r=1 → i_r=0100 in cycle 0, o_v=1, o_d=0xA5, o_id=2 the next cycle; ptr=3.
- Full contention: i_v=1111 held, o_r=1, 8 accepts → o_id sequence 0,1,2,3,0,1,2,3 with no bubble cycles.
- Backpressure: slot full with id 1 and o_r=0 for 5 cycles while i_v=1111 → i_r=0000, o_d and o_id stable, ptr unchanged. Raise o_r → id 1 drains and id 2 is loaded in the same edge.
- Wrap and skip: ptr=3, i_v=0011 → winner 0 and ptr becomes 1. Then i_v=0001 → winner 0 again.
- Asynchronous reset while full: assert reset mid-cycle with o_v=1 → o_v drops immediately, ptr=0, no i_r pulse. After release, i_v=1000 → o_id=3.

Source files
------------

// File: rtl/base_pkg.sv
// Shared helpers for the base_* arbitration blocks: index-width derivation
// and the consistency check between a requester count and its index width.
package base_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit idw_ok(input int ways, input int idw);
        return (idw >= 1) && (idw == clog2(ways));
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// otherwise the lowest requester overall.
module base_rr_pick #(
    parameter int ways = 4,
    parameter int idw  = 2
) (
    input  logic [ways-1:0] req,
    input  logic [idw-1:0]  ptr,
    output logic [ways-1:0] grant,
    output logic [idw-1:0]  idx,
    output logic            any
);

    logic [ways-1:0]   hi_mask;
    logic [2*ways-1:0] dbl;

    // Lower half holds requests at/above ptr, upper half all requests, so the
    // lowest set bit of the doubled vector is the round-robin winner.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < ways; k++) begin
            hi_mask[k] = (k >= int'(ptr));
        end
        dbl = {req, req & hi_mask};
        idx = '0;
        any = 1'b0;
        for (int j = 2 * ways - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                any = 1'b1;
                idx = (j >= ways) ? idw'(j - ways) : idw'(j);
            end
        end
        grant = any ? (ways'(1) << idx) : '0;
    end

endmodule

// File: rtl/base_rr_stage.sv
// Round-robin arbitrated pipeline stage: several valid/ready requesters share
// one registered output slot carrying the winner's data and index.
module base_rr_stage
    import base_pkg::*;
#(
    parameter int ways  = 4,
    parameter int width = 8,
    parameter int idw   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways-1:0]       i_v,
    input  logic [ways*width-1:0] i_d,
    output logic [ways-1:0]       i_r,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [width-1:0]      o_d,
    output logic [idw-1:0]        o_id
);

    generate
        if (!idw_ok(ways, idw)) begin : g_bad_idw
            $error("base_rr_stage: idw must equal clog2(ways) and be at least 1");
        end
    endgenerate

    logic [idw-1:0]  ptr;
    logic [idw-1:0]  win;
    logic [ways-1:0] grant;
    logic            any;
    logic            load;
    logic            accept;
    logic [idw-1:0]  ptr_next;

    base_rr_pick #(
        .ways (ways),
        .idw  (idw)
    ) u_pick (
        .req   (i_v),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    // The slot can take a new entry when empty or draining this cycle.
    assign load     = ~o_v | o_r;
    assign accept   = load & any;
    assign i_r      = (reset || !load) ? '0 : grant;
    assign ptr_next = (win == idw'(ways - 1)) ? '0 : win + 1'b1;

    // Output slot and priority pointer; ptr only advances on an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_v  <= 1'b0;
            o_d  <= '0;
            o_id <= '0;
            ptr  <= '0;
        end else if (accept) begin
            o_v  <= 1'b1;
            o_d  <= i_d[int'(win)*width +: width];
            o_id <= win;
            ptr  <= ptr_next;
        end else if (load) begin
            o_v  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_base_rr_stage.sv
// Self-checking bench for base_rr_stage: directed scenarios plus randomized
// traffic against a behavioural round-robin slot model.
module tb_base_rr_stage;

    localparam int WAYS  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WAYS-1:0]       i_v;
    logic [WAYS*WIDTH-1:0] i_d;
    logic [WAYS-1:0]       i_r;
    logic                  o_v;
    logic                  o_r;
    logic [WIDTH-1:0]      o_d;
    logic [IDW-1:0]        o_id;

    int tests = 0;
    int fails = 0;

    logic            m_v;
    logic [WIDTH-1:0] m_d;
    int              m_id;
    int              m_ptr;

    logic            chk_en = 1'b0;
    logic [WAYS-1:0] pend = '0;
    logic [WAYS*WIDTH-1:0] pdata = '0;

    base_rr_stage #(
        .ways  (WAYS),
        .width (WIDTH),
        .idw   (IDW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_d   (i_d),
        .i_r   (i_r),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_id  (o_id)
    );

    always #5 clk = ~clk;

    // Requesters must hold valid and data until their handshake completes.
    always @(posedge clk) begin
        if (chk_en && !reset) begin
            for (int k = 0; k < WAYS; k++) begin
                if (pend[k]) begin
                    tests++;
                    assert (i_v[k] && i_d[k*WIDTH +: WIDTH] == pdata[k*WIDTH +: WIDTH])
                    else begin
                        fails++;
                        $display("[TB] FAIL protocol lane %0d dropped v=%0b d=%0h held=%0h",
                                 k, i_v[k], i_d[k*WIDTH +: WIDTH], pdata[k*WIDTH +: WIDTH]);
                    end
                end
            end
            pend  = i_v & ~i_r;
            pdata = i_d;
        end
    end

    function automatic int m_winner(input logic [WAYS-1:0] v, input int p);
        for (int n = 0; n < WAYS; n++) begin
            if (v[(p + n) % WAYS]) return (p + n) % WAYS;
        end
        return -1;
    endfunction

    function automatic logic [WAYS-1:0] exp_ir();
        int w;
        w = m_winner(i_v, m_ptr);
        if (reset || w < 0 || !(!m_v || o_r)) return '0;
        return WAYS'(1) << w;
    endfunction

    task automatic model_reset();
        m_v   = 1'b0;
        m_d   = '0;
        m_id  = 0;
        m_ptr = 0;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then return at the following falling edge.
    task automatic tick();
        int   w;
        logic ld;
        w  = m_winner(i_v, m_ptr);
        ld = !m_v || o_r;
        @(posedge clk);
        if (!reset && ld) begin
            if (w >= 0) begin
                m_v   = 1'b1;
                m_d   = i_d[w*WIDTH +: WIDTH];
                m_id  = w;
                m_ptr = (w + 1) % WAYS;
            end else begin
                m_v = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_v   = '0;
        i_d   = '0;
        o_r   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_v   = 4'b1111;
        o_r   = 1'b1;
        #1;
        tests++;
        if (i_r !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_ir got %b want 0000", i_r);
        end
        @(negedge clk); @(negedge clk);
        tests++;
        if ({o_v, o_id, o_d} !== 11'd0 || i_r !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_state got v=%0b id=%0d d=%0h ir=%b want all 0", o_v, o_id, o_d, i_r);
        end
        reset = 1'b0;
        i_v   = '0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (o_v !== 1'b0 || i_r !== 4'b0000) begin
                fails++; $display("[TB] FAIL idle_cycle%0d got v=%0b ir=%b want 0/0000", c, o_v, i_r);
            end
        end
        tests++;
        if (dut.ptr !== 2'd0) begin
            fails++; $display("[TB] FAIL idle_ptr got %0d want 0", dut.ptr);
        end
    endtask

    task automatic test_single();
        do_reset();
        i_v = 4'b0100;
        i_d = 32'h00A5_0000;
        o_r = 1'b1;
        #1;
        tests++;
        if (i_r !== 4'b0100) begin
            fails++; $display("[TB] FAIL single_ir got %b want 0100", i_r);
        end
        tick();
        i_v = '0;
        tests++;
        if (o_v !== 1'b1 || o_d !== 8'hA5 || o_id !== 2'd2 || dut.ptr !== 2'd3) begin
            fails++; $display("[TB] FAIL single_out got v=%0b d=%0h id=%0d ptr=%0d want 1/a5/2/3", o_v, o_d, o_id, dut.ptr);
        end
        tick();
        tests++;
        if (o_v !== 1'b0 || dut.ptr !== 2'd3) begin
            fails++; $display("[TB] FAIL single_drain got v=%0b ptr=%0d want 0/3", o_v, dut.ptr);
        end
    endtask

    task automatic test_contention();
        logic [WAYS*WIDTH-1:0] data;
        data = 32'h44_33_22_11;
        do_reset();
        i_v = 4'b1111;
        i_d = data;
        o_r = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            tests++;
            if (i_r !== (4'b0001 << (n % 4))) begin
                fails++; $display("[TB] FAIL contend_ir%0d got %b want %b", n, i_r, 4'b0001 << (n % 4));
            end
            tick();
            tests++;
            if (o_v !== 1'b1 || o_id !== 2'(n % 4) || o_d !== data[(n % 4)*8 +: 8]) begin
                fails++; $display("[TB] FAIL contend_out%0d got v=%0b id=%0d d=%0h want 1/%0d/%0h",
                                  n, o_v, o_id, o_d, n % 4, data[(n % 4)*8 +: 8]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_v = 4'b0010;
        i_d = 32'h0000_5A00;
        o_r = 1'b0;
        tick();
        i_v = 4'b1111;
        i_d = 32'hD4_C3_5A_A1;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (i_r !== 4'b0000) begin
                fails++; $display("[TB] FAIL stall_ir%0d got %b want 0000", c, i_r);
            end
            tick();
            tests++;
            if (o_v !== 1'b1 || o_id !== 2'd1 || o_d !== 8'h5A || dut.ptr !== 2'd2) begin
                fails++; $display("[TB] FAIL stall_hold%0d got v=%0b id=%0d d=%0h ptr=%0d want 1/1/5a/2",
                                  c, o_v, o_id, o_d, dut.ptr);
            end
        end
        o_r = 1'b1;
        #1;
        tests++;
        if (i_r !== 4'b0100) begin
            fails++; $display("[TB] FAIL unstall_ir got %b want 0100", i_r);
        end
        tick();
        tests++;
        if (o_v !== 1'b1 || o_id !== 2'd2 || o_d !== 8'hC3) begin
            fails++; $display("[TB] FAIL unstall_out got v=%0b id=%0d d=%0h want 1/2/c3", o_v, o_id, o_d);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        i_v = 4'b0100;
        o_r = 1'b1;
        tick();
        i_v = 4'b0011;
        i_d = 32'h0000_B0B1;
        tick();
        tests++;
        if (o_id !== 2'd0 || o_d !== 8'hB1 || dut.ptr !== 2'd1) begin
            fails++; $display("[TB] FAIL wrap_out got id=%0d d=%0h ptr=%0d want 0/b1/1", o_id, o_d, dut.ptr);
        end
        i_v = 4'b0001;
        i_d = 32'h0000_00C7;
        tick();
        tests++;
        if (o_v !== 1'b1 || o_id !== 2'd0 || o_d !== 8'hC7 || dut.ptr !== 2'd1) begin
            fails++; $display("[TB] FAIL skip_out got v=%0b id=%0d d=%0h ptr=%0d want 1/0/c7/1", o_v, o_id, o_d, dut.ptr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_v = 4'b0001;
        i_d = 32'h0000_0033;
        o_r = 1'b1;
        tick();
        o_r = 1'b0;
        i_v = 4'b1111;
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (o_v !== 1'b0 || dut.ptr !== 2'd0 || i_r !== 4'b0000) begin
            fails++; $display("[TB] FAIL async_reset got v=%0b ptr=%0d ir=%b want 0/0/0000", o_v, dut.ptr, i_r);
        end
        o_r = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (o_v !== 1'b0 || i_r !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_hold got v=%0b ir=%b want 0/0000", o_v, i_r);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        i_v = 4'b1000;
        i_d = 32'h7E00_0000;
        tick();
        tests++;
        if (o_v !== 1'b1 || o_id !== 2'd3 || o_d !== 8'h7E) begin
            fails++; $display("[TB] FAIL post_reset got v=%0b id=%0d d=%0h want 1/3/7e", o_v, o_id, o_d);
        end
    endtask

    task automatic test_random();
        logic [WAYS-1:0] hs;
        logic [WAYS-1:0] eir;
        do_reset();
        pend   = '0;
        chk_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            o_r = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < WAYS; k++) begin
                if (!i_v[k] && $urandom_range(0, 1) == 1) begin
                    i_v[k] = 1'b1;
                    i_d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            #1;
            eir = exp_ir();
            tests++;
            if (i_r !== eir) begin
                fails++; $display("[TB] FAIL rand_ir c%0d got %b want %b", c, i_r, eir);
            end
            hs = i_v & i_r;
            tick();
            i_v = i_v & ~hs;
            tests++;
            if (o_v !== m_v || (m_v && (o_id !== 2'(m_id) || o_d !== m_d))) begin
                fails++; $display("[TB] FAIL rand_out c%0d got v=%0b id=%0d d=%0h want %0b/%0d/%0h",
                                  c, o_v, o_id, o_d, m_v, m_id, m_d);
            end
        end
        chk_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_v   = '0;
        i_d   = '0;
        o_r   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
